// File: rtl/muldiv_iter_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_iter_pkg
// Shared encodings for the iterative multiply/divide unit: FSM state
// encoding, operation select values and the ready_o polarity.
// -----------------------------------------------------------------------------
package muldiv_iter_pkg;

    // Two-bit state encoding, also visible on the unit's debug output.
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // op_div_i values
    localparam logic MD_OP_MUL = 1'b0;
    localparam logic MD_OP_DIV = 1'b1;

    // ready_o polarity
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/md_sign_fix.sv
// -----------------------------------------------------------------------------
// md_sign_fix
// Combinational conditional two's-complement negate. With i_neg driven by
// the operand sign it yields the magnitude; with i_neg driven by the result
// sign it performs the final sign fix-up.
//   i_val  [W-1:0]  value in
//   i_neg           1 = negate
//   o_val  [W-1:0]  i_neg ? -i_val : i_val
// -----------------------------------------------------------------------------
module md_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/muldiv_iter.sv
// -----------------------------------------------------------------------------
// muldiv_iter
// Iterative signed/unsigned multiply and divide sharing one datapath.
// One operand bit per cycle; WIDTH cycles per operation plus one DONE cycle.
//   clk, rst       clock, synchronous active-high reset
//   start_i        request; sampled only in IDLE (annul_i in the same cycle wins)
//   annul_i        cancel an operation in BUSY
//   op_div_i       0 = multiply, 1 = divide
//   signed_i       1 = two's-complement operands
//   opdata1_i/2_i  multiplicand/dividend, multiplier/divisor
//   busy_o         high in BUSY
//   ready_o        one-cycle pulse in DONE, result_o/dbz_o valid
//   result_o       {HI, LO}: product, or {remainder, quotient}
//   dbz_o          divide by zero; held until the next accepted start
//   dbg_state_o    current FSM state
//
// Handshake: an operation is accepted on a rising edge where the unit is IDLE,
// start_i=1 and annul_i=0. Exactly one ready_o pulse follows unless annul_i
// is seen in BUSY. result_o/dbz_o stay stable from DONE until the next
// accepted start (result_o also survives an annulled operation).
// -----------------------------------------------------------------------------
module muldiv_iter
    import muldiv_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic                 op_div_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    output logic                 busy_o,
    output logic                 ready_o,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 dbz_o,
    output logic [1:0]           dbg_state_o
);

    md_state_e            r_state;
    md_state_e            w_state_nxt;

    logic                 r_op_div;
    logic                 r_neg_res;     // product / quotient sign
    logic                 r_neg_rem;     // remainder follows dividend sign
    logic [WIDTH-1:0]     r_addend;      // |multiplicand| or |divisor|
    logic [2*WIDTH-1:0]   r_acc;         // MUL: {partial, multiplier}; DIV: {rem, quotient}
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_dbz;

    logic                 w_neg_a;
    logic                 w_neg_b;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic                 w_accept;
    logic                 w_dbz;
    logic                 w_last;
    logic [WIDTH-1:0]     w_hi;
    logic [WIDTH-1:0]     w_lo;
    logic [WIDTH:0]       w_mul_sum;
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH:0]       w_div_diff;
    logic [2*WIDTH-1:0]   w_acc_nxt;
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_quo_fix;
    logic [WIDTH-1:0]     w_rem_fix;
    logic [2*WIDTH-1:0]   w_final;

    // ---------------- operand magnitudes on entry ----------------
    assign w_neg_a = signed_i & opdata1_i[WIDTH-1];
    assign w_neg_b = signed_i & opdata2_i[WIDTH-1];

    md_sign_fix #(.W(WIDTH)) u_abs_a (.i_val(opdata1_i), .i_neg(w_neg_a), .o_val(w_mag_a));
    md_sign_fix #(.W(WIDTH)) u_abs_b (.i_val(opdata2_i), .i_neg(w_neg_b), .o_val(w_mag_b));

    assign w_accept = (r_state == MD_IDLE) & start_i & ~annul_i;
    assign w_dbz    = w_accept & (op_div_i == MD_OP_DIV) & (opdata2_i == '0);
    assign w_last   = (r_state == MD_BUSY) & ~annul_i & (r_cnt == CNT_W'(WIDTH - 1));

    // ---------------- one iteration ----------------
    assign w_hi        = r_acc[2*WIDTH-1:WIDTH];
    assign w_lo        = r_acc[WIDTH-1:0];
    assign w_mul_sum   = {1'b0, w_hi} + {1'b0, r_addend};
    // Remainder is always below the divisor, so WIDTH bits plus the incoming
    // dividend bit fit the (WIDTH+1)-bit trial value.
    assign w_div_shift = {w_hi, w_lo[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_addend};

    always_comb begin
        w_acc_nxt = r_acc;
        if (r_op_div == MD_OP_DIV) begin
            if (!w_div_diff[WIDTH])
                w_acc_nxt = {w_div_diff[WIDTH-1:0], w_lo[WIDTH-2:0], 1'b1};
            else
                w_acc_nxt = {w_div_shift[WIDTH-1:0], w_lo[WIDTH-2:0], 1'b0};
        end else begin
            // Shift-add: multiplier bits leave from the low half as the
            // product grows in from the top.
            if (w_lo[0])
                w_acc_nxt = {w_mul_sum, w_lo[WIDTH-1:1]};
            else
                w_acc_nxt = {1'b0, w_hi, w_lo[WIDTH-1:1]};
        end
    end

    // ---------------- sign fix-up into DONE ----------------
    md_sign_fix #(.W(2*WIDTH)) u_fix_prod (.i_val(w_acc_nxt), .i_neg(r_neg_res), .o_val(w_prod_fix));
    md_sign_fix #(.W(WIDTH)) u_fix_quo (.i_val(w_acc_nxt[WIDTH-1:0]), .i_neg(r_neg_res), .o_val(w_quo_fix));
    md_sign_fix #(.W(WIDTH)) u_fix_rem (.i_val(w_acc_nxt[2*WIDTH-1:WIDTH]), .i_neg(r_neg_rem), .o_val(w_rem_fix));

    assign w_final = (r_op_div == MD_OP_DIV) ? {w_rem_fix, w_quo_fix} : w_prod_fix;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= MD_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy_o      = 1'b0;
        ready_o     = DIV_RESULT_NOT_READY;
        dbg_state_o = r_state;
        unique case (r_state)
            MD_IDLE: begin
                if (w_dbz)         w_state_nxt = MD_DONE;
                else if (w_accept) w_state_nxt = MD_BUSY;
            end
            MD_BUSY: begin
                busy_o = 1'b1;
                if (annul_i)     w_state_nxt = MD_IDLE;
                else if (w_last) w_state_nxt = MD_DONE;
            end
            MD_DONE: begin
                ready_o     = DIV_RESULT_READY;
                w_state_nxt = MD_IDLE;
            end
            default: w_state_nxt = MD_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_div  <= MD_OP_MUL;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_addend  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_dbz     <= 1'b0;
        end else if (w_accept) begin
            r_op_div  <= op_div_i;
            r_neg_res <= w_neg_a ^ w_neg_b;
            r_neg_rem <= w_neg_a;
            r_cnt     <= '0;
            if (op_div_i == MD_OP_DIV) begin
                r_acc    <= {{WIDTH{1'b0}}, w_mag_a};
                r_addend <= w_mag_b;
            end else begin
                r_acc    <= {{WIDTH{1'b0}}, w_mag_b};
                r_addend <= w_mag_a;
            end
            r_dbz <= w_dbz;
            if (w_dbz)
                r_result <= {opdata1_i, {WIDTH{1'b1}}};
        end else if ((r_state == MD_BUSY) && !annul_i) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last)
                r_result <= w_final;
        end
    end

    assign result_o = r_result;
    assign dbz_o    = r_dbz;

endmodule

// File: tb/tb_muldiv_iter.sv
module tb_muldiv_iter;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start_i;
    logic           annul_i;
    logic           op_div_i;
    logic           signed_i;
    logic [W-1:0]   opdata1_i;
    logic [W-1:0]   opdata2_i;
    logic           busy_o;
    logic           ready_o;
    logic [2*W-1:0] result_o;
    logic           dbz_o;
    logic [1:0]     dbg_state_o;

    muldiv_iter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i),
        .op_div_i(op_div_i), .signed_i(signed_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
        .busy_o(busy_o), .ready_o(ready_o), .result_o(result_o),
        .dbz_o(dbz_o), .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_exp = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference model: plain integer arithmetic on 64-bit values.
    function automatic logic [63:0] model(input logic div, input logic sgn,
                                          input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] q, m, r;
        if (div && b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        if (!div) begin
            r = 64'(sa * sb);
        end else begin
            q = 64'(sa / sb);
            m = 64'(sa % sb);
            r = {m[31:0], q[31:0]};
        end
        return r;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a negedge; start is seen on the next rising edge, then the
    // inputs are scrambled so only the latched copies can matter.
    task automatic drive_start(input logic div, input logic sgn,
                               input logic [31:0] a, input logic [31:0] b);
        start_i   = 1'b1;
        op_div_i  = div;
        signed_i  = sgn;
        opdata1_i = a;
        opdata2_i = b;
        @(negedge clk);
        start_i   = 1'b0;
        op_div_i  = 1'($urandom);
        signed_i  = 1'($urandom);
        opdata1_i = 32'($urandom);
        opdata2_i = 32'($urandom);
    endtask

    // Entered at the negedge of cycle T+1. disturb_at > 0 raises start_i
    // with new operands for two cycles while BUSY.
    task automatic wait_result(input string tag, input int exp_lat,
                               input logic exp_dbz, input int disturb_at);
        int          lat;
        int          busy_cnt;
        logic [63:0] exp;
        exp      = exp_q.pop_front();
        last_exp = exp;
        lat      = 1;
        busy_cnt = 0;
        while (ready_o !== 1'b1 && lat < 100) begin
            if (busy_o === 1'b1) busy_cnt++;
            if (disturb_at > 0 && lat == disturb_at) begin
                start_i   = 1'b1;
                op_div_i  = ~op_div_i;
                opdata1_i = 32'($urandom);
                opdata2_i = 32'($urandom);
            end
            if (disturb_at > 0 && lat == disturb_at + 2) start_i = 1'b0;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_result"}, result_o, exp);
        check({tag, "_dbz"}, 64'(dbz_o), 64'(exp_dbz));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
        @(negedge clk);
        check({tag, "_ready_pulse"}, 64'(ready_o), 64'd0);
        check({tag, "_idle_after"}, 64'(busy_o), 64'd0);
        check({tag, "_result_hold"}, result_o, exp);
        check({tag, "_dbz_hold"}, 64'(dbz_o), 64'(exp_dbz));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ready_seen;
        rst       = 1'b1;
        start_i   = 1'b0;
        annul_i   = 1'b0;
        op_div_i  = 1'b0;
        signed_i  = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy_o), 64'd0);
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        check("reset_dbz", 64'(dbz_o), 64'd0);
        check("reset_state", 64'(dbg_state_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Unsigned MUL max * max
        exp_q.push_back(model(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
        drive_start(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("umul_max", 33, 1'b0, 0);
        check("umul_max_const", result_o, 64'hFFFF_FFFE_0000_0001);

        // Signed DIV -7 / 2
        exp_q.push_back(model(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2));
        drive_start(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_result("sdiv_m7_2", 33, 1'b0, 0);
        check("sdiv_m7_2_const", result_o, 64'hFFFF_FFFF_FFFF_FFFD);

        // Signed MUL MIN * MIN
        exp_q.push_back(model(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000));
        drive_start(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000);
        wait_result("smul_min", 33, 1'b0, 0);
        check("smul_min_const", result_o, 64'h4000_0000_0000_0000);

        // Signed DIV MIN / -1
        exp_q.push_back(model(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF));
        drive_start(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_result("sdiv_min_m1", 33, 1'b0, 0);
        check("sdiv_min_m1_const", result_o, 64'h0000_0000_8000_0000);

        // Unsigned DIV 100 / 0
        exp_q.push_back(model(1'b1, 1'b0, 32'd100, 32'd0));
        drive_start(1'b1, 1'b0, 32'd100, 32'd0);
        wait_result("udiv_dbz", 1, 1'b1, 0);
        check("udiv_dbz_const", result_o, 64'h0000_0064_FFFF_FFFF);

        // Annul a DIV at T+10; result of the previous op must survive
        drive_start(1'b1, 1'b0, 32'd1000, 32'd7);
        check("dbz_clear_on_start", 64'(dbz_o), 64'd0);
        repeat (9) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        check("annul_busy", 64'(busy_o), 64'd0);
        check("annul_state", 64'(dbg_state_o), 64'd0);
        ready_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (ready_o === 1'b1) ready_seen++;
            @(negedge clk);
        end
        check("annul_no_ready", 64'(ready_seen), 64'd0);
        check("annul_result_kept", result_o, last_exp);

        // start and annul together in IDLE
        start_i  = 1'b1;
        annul_i  = 1'b1;
        op_div_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        annul_i = 1'b0;
        check("start_annul_busy", 64'(busy_o), 64'd0);
        @(negedge clk);
        check("start_annul_ready", 64'(ready_o), 64'd0);

        // Operand change and a second start while BUSY
        exp_q.push_back(model(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd12345));
        drive_start(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd12345);
        wait_result("busy_restart", 33, 1'b0, 5);

        // Re-start in the IDLE cycle right after DONE
        exp_q.push_back(model(1'b1, 1'b0, 32'hDEAD_BEEF, 32'd1234));
        drive_start(1'b1, 1'b0, 32'hDEAD_BEEF, 32'd1234);
        wait_result("back_to_back", 33, 1'b0, 0);

        // Reset mid-BUSY
        exp_q.push_back(model(1'b1, 1'b0, 32'd100, 32'd0));
        drive_start(1'b1, 1'b0, 32'd100, 32'd0);
        wait_result("dbz_before_rst", 1, 1'b1, 0);
        drive_start(1'b0, 1'b0, 32'd77, 32'd99);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_ready", 64'(ready_o), 64'd0);
        check("midrst_result", result_o, 64'd0);
        check("midrst_dbz", 64'(dbz_o), 64'd0);
        check("midrst_state", 64'(dbg_state_o), 64'd0);
        exp_q.push_back(model(1'b0, 1'b0, 32'd77, 32'd99));
        drive_start(1'b0, 1'b0, 32'd77, 32'd99);
        wait_result("after_rst", 33, 1'b0, 0);

        // Randomized operations against the model
        for (int n = 0; n < 30; n++) begin
            logic        div;
            logic        sgn;
            logic [31:0] a;
            logic [31:0] b;
            div = 1'($urandom_range(0, 1));
            sgn = 1'($urandom_range(0, 1));
            a   = pick();
            b   = pick();
            exp_q.push_back(model(div, sgn, a, b));
            drive_start(div, sgn, a, b);
            wait_result($sformatf("rand%0d", n), (div && b == 32'd0) ? 1 : 33,
                        div && b == 32'd0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
